bin2bcd_seq: RTL and testbench

Sequential shift-and-add-3 (double-dabble) binary-to-BCD converter. Sits downstream of the Collatz range engine and the start/index logic. Converts the binary iteration count or the start value into decimal digits that feed the hex7seg decoders, so HEX shows decimal instead of hex. Handles one conversion at a time with a start/done handshake; the result is held stable between conversions.

---
 rtl/bin2bcd_seq.sv | 130 +++++++++++++
 tb/tb_bin2bcd_seq.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/bin2bcd_seq.sv
// Sequential shift-and-add-3 (double-dabble) binary-to-BCD converter.
// One conversion at a time; results are held between conversions.
module bin2bcd_seq #(
    parameter int unsigned IN_WIDTH = 16,
    parameter int unsigned DIGITS   = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [IN_WIDTH-1:0]   bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  overflow,
    output logic [DIGITS-1:0]     blank
);

    // Scratch holds ceil(IN_WIDTH*log10(2))+1 digits so no value is ever lost.
    localparam int SD = int'((IN_WIDTH * 30103 + 99999) / 100000) + 1;
    localparam int CW = $clog2(IN_WIDTH + 1);
    localparam int SW = 4 * SD + IN_WIDTH;
    localparam logic [DIGITS-1:0] BlankRst = {DIGITS{1'b1}} << 1;

    typedef enum logic [0:0] {StIdle, StShift} state_e;

    state_e                state_q, state_d;
    logic [IN_WIDTH-1:0]   sreg_q, sreg_d;
    logic [4*SD-1:0]       scr_q, scr_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  done_q, done_d;
    logic [4*DIGITS-1:0]   bcd_q, bcd_d;
    logic                  ovf_q, ovf_d;
    logic [DIGITS-1:0]     blank_q, blank_d;

    logic [4*SD-1:0]          adj;
    logic [SW-1:0]            step;
    logic [4*(SD+DIGITS)-1:0] scr_pad;
    logic [4*DIGITS-1:0]      res_bcd;
    logic                     res_ovf;
    logic [DIGITS-1:0]        res_blank;
    logic                     zero_run;

    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        scr_d   = scr_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        bcd_d   = bcd_q;
        ovf_d   = ovf_q;
        blank_d = blank_q;

        adj = scr_q;
        for (int k = 0; k < SD; k++) begin
            if (scr_q[4*k+:4] >= 4'd5) adj[4*k+:4] = scr_q[4*k+:4] + 4'd3;
        end
        step = {adj, sreg_q} << 1;

        // Pad so the presented window and the overflow test work for any DIGITS vs SD.
        scr_pad   = {{(4*DIGITS){1'b0}}, step[SW-1:IN_WIDTH]};
        res_bcd   = scr_pad[4*DIGITS-1:0];
        res_ovf   = |(scr_pad >> (4*DIGITS));
        res_blank = '0;
        zero_run  = 1'b1;
        for (int k = int'(DIGITS) - 1; k >= 1; k--) begin
            zero_run     = zero_run & (res_bcd[4*k+:4] == 4'd0);
            res_blank[k] = zero_run & ~res_ovf;
        end

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    sreg_d  = bin;
                    scr_d   = '0;
                    cnt_d   = CW'(IN_WIDTH);
                    state_d = StShift;
                end
            end
            StShift: begin
                sreg_d = step[IN_WIDTH-1:0];
                scr_d  = step[SW-1:IN_WIDTH];
                cnt_d  = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    done_d  = 1'b1;
                    bcd_d   = res_bcd;
                    ovf_d   = res_ovf;
                    blank_d = res_blank;
                    // Completing edge is also an accepting edge: back-to-back every IN_WIDTH.
                    if (start) begin
                        sreg_d = bin;
                        scr_d  = '0;
                        cnt_d  = CW'(IN_WIDTH);
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            sreg_q  <= '0;
            scr_q   <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            bcd_q   <= '0;
            ovf_q   <= 1'b0;
            blank_q <= BlankRst;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            scr_q   <= scr_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            bcd_q   <= bcd_d;
            ovf_q   <= ovf_d;
            blank_q <= blank_d;
        end
    end

    assign busy     = (state_q == StShift);
    assign done     = done_q;
    assign bcd      = bcd_q;
    assign overflow = ovf_q;
    assign blank    = blank_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Scoreboard bench for bin2bcd_seq: a 16-bit/5-digit and a 12-bit/3-digit instance.
module tb_bin2bcd_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, start, busy, done, ovf;
    logic [15:0] bin;
    logic [19:0] bcd;
    logic [4:0]  blank;
    logic        start2, busy2, done2, ovf2;
    logic [11:0] bin2, bcd2;
    logic [2:0]  blank2;

    bin2bcd_seq #(.IN_WIDTH(16), .DIGITS(5)) u_dut (
        .clk(clk), .reset(reset), .start(start), .bin(bin), .busy(busy), .done(done),
        .bcd(bcd), .overflow(ovf), .blank(blank)
    );

    bin2bcd_seq #(.IN_WIDTH(12), .DIGITS(3)) u_dut2 (
        .clk(clk), .reset(reset), .start(start2), .bin(bin2), .busy(busy2), .done(done2),
        .bcd(bcd2), .overflow(ovf2), .blank(blank2)
    );

    typedef struct {
        logic [19:0] bcd;
        logic        ovf;
        logic [4:0]  blank;
        int          cyc;
    } exp_t;

    exp_t q1[$], q2[$];
    exp_t cur1, cur2, e1, e2;
    int   total = 0, bad = 0, cyc = 0, nbusy;
    bit   mon_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called just before the edge that accepts the start.
    task automatic push1(input logic [19:0] b, input logic o, input logic [4:0] bl);
        q1.push_back('{bcd: b, ovf: o, blank: bl, cyc: cyc + 17});
    endtask

    task automatic push2(input logic [11:0] b, input logic o, input logic [2:0] bl);
        q2.push_back('{bcd: {8'h0, b}, ovf: o, blank: {2'b0, bl}, cyc: cyc + 13});
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (done === 1'b1) begin
                if (q1.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL d1 unexpected done: got done=1 want none (cycle %0d)", cyc);
                end else begin
                    e1 = q1.pop_front();
                    check("d1 bcd", 32'(bcd), 32'(e1.bcd));
                    check("d1 ovf", 32'(ovf), 32'(e1.ovf));
                    check("d1 blank", 32'(blank), 32'(e1.blank));
                    check("d1 done cycle", cyc, e1.cyc);
                    cur1 = e1;
                end
            end else begin
                check("d1 hold bcd", 32'(bcd), 32'(cur1.bcd));
                check("d1 hold ovf/blank", {26'b0, ovf, blank}, {26'b0, cur1.ovf, cur1.blank});
            end
            if (done2 === 1'b1) begin
                if (q2.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL d2 unexpected done: got done=1 want none (cycle %0d)", cyc);
                end else begin
                    e2 = q2.pop_front();
                    check("d2 bcd", 32'(bcd2), 32'(e2.bcd[11:0]));
                    check("d2 ovf", 32'(ovf2), 32'(e2.ovf));
                    check("d2 blank", 32'(blank2), 32'(e2.blank[2:0]));
                    check("d2 done cycle", cyc, e2.cyc);
                    cur2 = e2;
                end
            end else begin
                check("d2 hold", {16'b0, ovf2, blank2, bcd2}, {16'b0, cur2.ovf, cur2.blank[2:0],
                      cur2.bcd[11:0]});
            end
        end
    end

    logic [15:0] v4 [4];
    logic [19:0] b4 [4];
    logic [4:0]  k4 [4];

    initial begin
        v4[0] = 16'd42;    b4[0] = 20'h00042; k4[0] = 5'b11100;
        v4[1] = 16'd9999;  b4[1] = 20'h09999; k4[1] = 5'b10000;
        v4[2] = 16'd10000; b4[2] = 20'h10000; k4[2] = 5'b00000;
        v4[3] = 16'd65000; b4[3] = 20'h65000; k4[3] = 5'b00000;

        reset = 1'b1; start = 1'b0; bin = '0; start2 = 1'b0; bin2 = '0;
        repeat (3) tick();
        reset = 1'b0;
        cur1 = '{bcd: 20'h0, ovf: 1'b0, blank: 5'b11110, cyc: 0};
        cur2 = '{bcd: 20'h0, ovf: 1'b0, blank: 5'b00110, cyc: 0};
        tick();
        mon_en = 1'b1;
        check("rst busy", 32'(busy), 32'd0);
        check("rst done", 32'(done), 32'd0);
        check("rst bcd", 32'(bcd), 32'h0);
        check("rst blank", 32'(blank), 32'b11110);
        check("rst ovf", 32'(ovf), 32'd0);
        check("rst2 blank", 32'(blank2), 32'b110);

        // 65535: busy for exactly 16 cycles, then stable
        start = 1'b1; bin = 16'hFFFF; push1(20'h65535, 1'b0, 5'b00000);
        tick();
        start = 1'b0; bin = 16'h1234;
        nbusy = 0;
        for (int i = 0; i < 20; i++) begin
            if (busy) nbusy++;
            tick();
        end
        check("busy cycles", nbusy, 16);
        repeat (20) tick();

        // Back-to-back chain 0, 7, 111
        start = 1'b1; bin = 16'd0; push1(20'h00000, 1'b0, 5'b11110);
        repeat (16) tick();
        bin = 16'd7; push1(20'h00007, 1'b0, 5'b11110);
        repeat (16) tick();
        bin = 16'd111; push1(20'h00111, 1'b0, 5'b11000);
        tick();
        start = 1'b0;
        repeat (20) tick();

        // Narrow instance: overflow and full-range values
        start2 = 1'b1; bin2 = 12'd4095; push2(12'h095, 1'b1, 3'b000);
        tick();
        start2 = 1'b0;
        repeat (14) tick();
        start2 = 1'b1; bin2 = 12'd999; push2(12'h999, 1'b0, 3'b000);
        tick();
        start2 = 1'b0;
        repeat (14) tick();
        start2 = 1'b1; bin2 = 12'd5; push2(12'h005, 1'b0, 3'b110);
        tick();
        start2 = 1'b0;
        repeat (14) tick();

        // start held high, bin churns while busy
        start = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bin = v4[i]; push1(b4[i], 1'b0, k4[i]);
            tick();
            for (int j = 1; j < 16; j++) begin
                bin = 16'($urandom);
                tick();
            end
        end
        start = 1'b0;
        repeat (20) tick();

        // Reset mid-conversion aborts with no done
        start = 1'b1; bin = 16'd1234;
        tick();
        start = 1'b0;
        repeat (7) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        cur1 = '{bcd: 20'h0, ovf: 1'b0, blank: 5'b11110, cyc: 0};
        cur2 = '{bcd: 20'h0, ovf: 1'b0, blank: 5'b00110, cyc: 0};
        check("abort busy", 32'(busy), 32'd0);
        check("abort done", 32'(done), 32'd0);
        check("abort bcd", 32'(bcd), 32'h0);
        check("abort blank", 32'(blank), 32'b11110);
        repeat (20) tick();
        start = 1'b1; bin = 16'd1234; push1(20'h01234, 1'b0, 5'b10000);
        tick();
        start = 1'b0;
        repeat (20) tick();

        for (int i = 0; i < 50 && (q1.size() != 0 || q2.size() != 0); i++) tick();
        check("q1 drained", 32'(q1.size()), 32'd0);
        check("q2 drained", 32'(q2.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
